// File: rtl/loop_filter.sv
// -----------------------------------------------------------------------------
// loop_filter
//   Proportional-integral loop filter for the all-digital PLL. Every rising
//   edge of the generated clock it takes a signed phase-error word and
//   produces an unsigned DCO control code centred on MID. An optional
//   two-gear mode runs both gains x4 during acquisition and drops back to
//   nominal gain once the error has stayed within +/-1 for 16 cycles.
//
// Ports
//   gen_clk_i  in   1             clock, rising edge
//   reset_i    in   1             synchronous, active-high reset
//   error_i    in   ERROR_WIDTH   two's-complement phase error
//   dco_cc_o   out  DCO_CC_WIDTH  registered unsigned DCO control code
// -----------------------------------------------------------------------------
module loop_filter #(
    parameter int                    ERROR_WIDTH   = 8,
    parameter int                    DCO_CC_WIDTH  = 9,
    parameter int                    KP_WIDTH      = 5,
    parameter int                    KP_FRAC_WIDTH = 4,
    parameter logic [KP_WIDTH-1:0]   KP            = 5'b01001,
    parameter int                    KI_WIDTH      = 8,
    parameter int                    KI_FRAC_WIDTH = 7,
    parameter logic [KI_WIDTH-1:0]   KI            = 8'b00000001,
    parameter int                    DYNAMIC_VAL   = 0
) (
    input  logic                    gen_clk_i,
    input  logic                    reset_i,
    input  logic [ERROR_WIDTH-1:0]  error_i,
    output logic [DCO_CC_WIDTH-1:0] dco_cc_o
);

    // Common fractional alignment of all internal sums.
    localparam int F     = (KP_FRAC_WIDTH > KI_FRAC_WIDTH) ? KP_FRAC_WIDTH : KI_FRAC_WIDTH;
    localparam int GW    = (KP_WIDTH > KI_WIDTH) ? KP_WIDTH : KI_WIDTH;
    localparam int P_SH  = F - KP_FRAC_WIDTH;
    localparam int I_SH  = F - KI_FRAC_WIDTH;
    // One working width for every signed quantity: exact product, gear shift,
    // fractional alignment, plus headroom for P + I and the MID offset.
    // The integrator lives in this width too, which leaves well over two
    // guard bits above the clamp limit.
    localparam int SW    = ERROR_WIDTH + GW + 1 + 2 + F + DCO_CC_WIDTH + 2;

    localparam logic signed [SW-1:0] ONE   = SW'(1);
    localparam logic signed [SW-1:0] LIM   = ONE <<< (DCO_CC_WIDTH - 1 + F);
    localparam logic signed [SW-1:0] MIDW  = ONE <<< (DCO_CC_WIDTH - 1);
    localparam logic signed [SW-1:0] MAXW  = (ONE <<< DCO_CC_WIDTH) - ONE;
    localparam logic [DCO_CC_WIDTH-1:0] MID_CC = DCO_CC_WIDTH'(1) << (DCO_CC_WIDTH - 1);

    typedef enum logic {ACQUIRE, TRACK} gear_t;

    gear_t                    r_gear;
    logic [3:0]               r_cnt;
    logic signed [SW-1:0]     r_integ;
    logic [DCO_CC_WIDTH-1:0]  r_cc;

    logic signed [SW-1:0]     w_err;
    logic signed [SW-1:0]     w_kp;
    logic signed [SW-1:0]     w_ki;
    logic [1:0]               w_g;
    logic signed [SW-1:0]     w_p;
    logic signed [SW-1:0]     w_inc;
    logic signed [SW-1:0]     w_isum;
    logic signed [SW-1:0]     w_inext;
    logic signed [SW-1:0]     w_s;
    logic signed [SW-1:0]     w_cc;
    logic [DCO_CC_WIDTH-1:0]  w_cc_sat;
    logic                     w_small;

    // Sign-extend the error before anything else so the most negative code
    // is carried exactly; gains are zero-extended (they are unsigned).
    assign w_err = {{(SW-ERROR_WIDTH){error_i[ERROR_WIDTH-1]}}, error_i};
    assign w_kp  = {{(SW-KP_WIDTH){1'b0}}, KP};
    assign w_ki  = {{(SW-KI_WIDTH){1'b0}}, KI};

    assign w_g     = (DYNAMIC_VAL != 0 && r_gear == ACQUIRE) ? 2'd2 : 2'd0;
    assign w_small = (w_err >= -ONE) && (w_err <= ONE);

    assign w_p   = ((w_err * w_kp) <<< w_g) <<< P_SH;
    assign w_inc = ((w_err * w_ki) <<< w_g) <<< I_SH;
    assign w_isum = r_integ + w_inc;

    // Anti-windup clamp; output saturation below never feeds back here.
    always_comb begin
        w_inext = w_isum;
        if (w_isum > LIM)
            w_inext = LIM;
        else if (w_isum < -LIM)
            w_inext = -LIM;
    end

    // Arithmetic shift gives floor division by 2^F.
    assign w_s  = (w_p + w_inext) >>> F;
    assign w_cc = w_s + MIDW;

    always_comb begin
        w_cc_sat = w_cc[DCO_CC_WIDTH-1:0];
        if (w_cc < 0)
            w_cc_sat = '0;
        else if (w_cc > MAXW)
            w_cc_sat = '1;
    end

    always_ff @(posedge gen_clk_i) begin
        if (reset_i) begin
            r_cc    <= MID_CC;
            r_integ <= '0;
            r_cnt   <= '0;
            r_gear  <= ACQUIRE;
        end else begin
            r_cc    <= w_cc_sat;
            r_integ <= w_inext;
            // Gear machine: 16 consecutive small errors leave ACQUIRE for good.
            if (r_gear == ACQUIRE) begin
                if (w_small) begin
                    if (r_cnt == 4'd15) begin
                        r_gear <= TRACK;
                        r_cnt  <= '0;
                    end else begin
                        r_cnt  <= r_cnt + 4'd1;
                    end
                end else begin
                    r_cnt <= '0;
                end
            end
        end
    end

    assign dco_cc_o = r_cc;

endmodule

// File: tb/tb_loop_filter.sv
// -----------------------------------------------------------------------------
// tb_loop_filter
//   Drives a static-gain and a gear-shifting loop_filter from the same error
//   and reset stream. Expected codes are pushed to one queue per instance when
//   a sample is driven and popped after the following rising edge. Directed
//   phases push hand-derived codes; the random phase pushes codes from an
//   integer reference model.
// -----------------------------------------------------------------------------
module tb_loop_filter;

    localparam int EW = 4;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [EW-1:0] err;
    logic [CW-1:0] cc_s, cc_d;

    int n_chk  = 0;
    int n_fail = 0;

    int q_s[$];
    int q_d[$];
    int last_d;

    // reference model state (one per instance)
    longint m_i_s, m_i_d;
    int     m_cnt;
    bit     m_acq;

    always #5 clk = ~clk;

    loop_filter #(
        .ERROR_WIDTH(EW), .DCO_CC_WIDTH(CW),
        .KP_WIDTH(5), .KP_FRAC_WIDTH(0), .KP(5'd4),
        .KI_WIDTH(8), .KI_FRAC_WIDTH(3), .KI(8'd16),
        .DYNAMIC_VAL(0)
    ) u_dut_s (
        .gen_clk_i(clk), .reset_i(rst), .error_i(err), .dco_cc_o(cc_s)
    );

    loop_filter #(
        .ERROR_WIDTH(EW), .DCO_CC_WIDTH(CW),
        .KP_WIDTH(5), .KP_FRAC_WIDTH(0), .KP(5'd4),
        .KI_WIDTH(8), .KI_FRAC_WIDTH(3), .KI(8'd16),
        .DYNAMIC_VAL(1)
    ) u_dut_d (
        .gen_clk_i(clk), .reset_i(rst), .error_i(err), .dco_cc_o(cc_d)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One cycle of the PI filter in plain integers (KP=4, KI=2.0, 8 frac units).
    function automatic int model_step(input int e, input int gain, inout longint integ);
        longint p, t, s, o;
        p = longint'(e) * 4 * gain * 8;
        integ = integ + longint'(e) * 2 * gain * 8;
        if (integ > 128)  integ = 128;
        if (integ < -128) integ = -128;
        t = p + integ;
        s = (t >= 0) ? t / 8 : -((-t + 7) / 8);
        o = 16 + s;
        if (o < 0)  o = 0;
        if (o > 31) o = 31;
        return int'(o);
    endfunction

    // Drive one sample; exp < 0 means "take the reference model's value".
    task automatic step(input int e, input bit r, input int exp_s, input int exp_d);
        int ms, md;
        @(negedge clk);
        rst = r;
        err = EW'(e);
        if (r) begin
            m_i_s = 0; m_i_d = 0; m_cnt = 0; m_acq = 1;
            ms = 16; md = 16;
        end else begin
            ms = model_step(e, 1, m_i_s);
            md = model_step(e, m_acq ? 4 : 1, m_i_d);
            if (m_acq) begin
                if (e >= -1 && e <= 1) begin
                    if (m_cnt == 15) m_acq = 0;
                    else m_cnt++;
                end else begin
                    m_cnt = 0;
                end
            end
        end
        q_s.push_back(exp_s >= 0 ? exp_s : ms);
        q_d.push_back(exp_d >= 0 ? exp_d : md);
        @(posedge clk);
        #1;
        chk("static_cc", int'(cc_s), q_s.pop_front());
        chk("dynamic_cc", int'(cc_d), q_d.pop_front());
        last_d = int'(cc_d);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int prev;
        int exp_up[10] = '{22, 24, 26, 28, 30, 31, 31, 31, 31, 31};
        rst = 1'b1;
        err = '0;
        m_i_s = 0; m_i_d = 0; m_cnt = 0; m_acq = 1;

        // reset held two edges with a nonzero error, then release with 0
        step(5, 1, 16, 16);
        step(-3, 1, 16, 16);
        step(0, 0, 16, 16);

        // constant +1: ramp then positive saturation; dynamic gear starts at 31
        step(0, 1, 16, 16);
        for (int i = 0; i < 10; i++)
            step(1, 0, exp_up[i], (i == 0) ? 31 : -1);
        // anti-windup: integrator was clamped, so recovery is immediate
        step(0, 0, 31, -1);
        step(-1, 0, 26, -1);

        // negative saturation and mid-run reset
        step(0, 1, 16, 16);
        for (int i = 0; i < 3; i++)
            step(-6, 0, 0, -1);
        step(-6, 1, 16, 16);

        // most negative error, exactly clamped, no wrap
        step(-8, 0, 0, -1);
        step(0, 0, 0, -1);
        step(0, 0, 0, -1);

        // gear shift: x4 gains, 16 quiet cycles, then a nominal-gain step
        step(0, 1, 16, 16);
        step(1, 0, -1, 31);
        for (int i = 0; i < 16; i++)
            step(0, 0, -1, (i == 15) ? 24 : -1);
        prev = last_d;
        step(1, 0, -1, 30);
        chk("track_step_delta", last_d - prev, 6);

        // random stream with occasional resets, checked against the model
        for (int i = 0; i < 300; i++)
            step($urandom_range(15) - 8, ($urandom_range(29) == 0), -1, -1);

        chk("queues_drained", q_s.size() + q_d.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
